// File: rtl/srl_readback_pkg.sv
// Shared types and helpers for the SRL shift chain with handshaked full-chain readback.
package srl_readback_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Address width for a power-of-two depth in 2..64, evaluated at elaboration.
    function automatic int aw_of(input int depth);
        int w;
        w = 1;
        for (int i = 1; i <= 6; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/srl_readback_chain.sv
// Reset-free shift chain with a clock enable and two dynamic read ports, shaped for SRL mapping.
module srl_chain
    import srl_readback_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 32,
    parameter int AW    = aw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [N-1:0]  din,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic [N-1:0]  dout0,
    output logic [N-1:0]  dout1
);

    logic [N-1:0] taps [DEPTH];

    // NOTE: storage is deliberately left out of reset; a reset term stops the tools from packing it into shift-register primitives.
    always_ff @(posedge clk) begin
        if (ce) begin
            taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    assign dout0 = taps[raddr0];
    assign dout1 = taps[raddr1];

endmodule

// File: rtl/srl_readback.sv
// Shift chain front end plus an IDLE/SEND readback that streams every tap, newest first.
module srl_readback
    import srl_readback_pkg::*;
#(
    parameter int  N     = 8,
    parameter int  DEPTH = 32,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  a,
    input  logic          e,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  z,
    input  logic          start,
    output logic          busy,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [N-1:0]  dump_data,
    output logic [AW-1:0] dump_idx,
    output logic          dump_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] idx_d;
    logic          shift_en;

    // Reset wins over shifting, and the chain is frozen for the whole readback.
    assign shift_en = e & ~busy & ~rst;

    srl_chain #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_chain (
        .clk    (clk),
        .ce     (shift_en),
        .din    (a),
        .raddr0 (addr),
        .raddr1 (dump_idx),
        .dout0  (z),
        .dout1  (dump_data)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = dump_idx;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = dump_idx + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dump_idx <= '0;
        end else begin
            state_q  <= state_d;
            dump_idx <= idx_d;
        end
    end

    assign busy       = (state_q == SEND);
    assign dump_valid = busy;
    assign dump_last  = busy && (dump_idx == LAST_IDX);

endmodule

// File: tb/tb_srl_readback.sv
// Directed self-checking bench: fill, enable gating, full-speed dump, backpressure, abort, start+shift.
module tb_srl_readback;

    localparam int N     = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  a;
    logic          e;
    logic [AW-1:0] addr;
    logic [N-1:0]  z;
    logic          start;
    logic          busy;
    logic          dump_valid;
    logic          dump_ready;
    logic [N-1:0]  dump_data;
    logic [AW-1:0] dump_idx;
    logic          dump_last;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] m [DEPTH];
    logic [N-1:0] got_first;
    logic [N-1:0] got_last;

    srl_readback #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .e          (e),
        .addr       (addr),
        .z          (z),
        .start      (start),
        .busy       (busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_last  (dump_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_shift(input logic [N-1:0] v);
        for (int k = DEPTH - 1; k > 0; k--) m[k] = m[k-1];
        m[0] = v;
    endtask

    task automatic begin_dump(input logic with_e, input logic [N-1:0] av);
        @(negedge clk);
        start = 1'b1;
        e     = with_e;
        a     = av;
        if (with_e) model_shift(av);
        @(posedge clk);
        #1;
        start = 1'b0;
        e     = 1'b0;
    endtask

    task automatic dump_all(input string tag);
        dump_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check({tag, "_valid"}, dump_valid, 1'b1);
            check({tag, "_idx"}, dump_idx, i);
            check({tag, "_data"}, dump_data, m[i]);
            check({tag, "_last"}, dump_last, (i == DEPTH - 1));
            if (i == 0) got_first = dump_data;
            if (i == DEPTH - 1) got_last = dump_data;
        end
        @(negedge clk);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_valid_end"}, dump_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        logic [N-1:0] old30;
        int exp_i;
        int cyc;

        rst = 1'b1; a = '0; e = 1'b0; addr = '0; start = 1'b0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", dump_valid, 1'b0);
        check("rst_idx", dump_idx, 0);
        check("rst_last", dump_last, 1'b0);
        rst = 1'b0;

        // Fill with 1..32, then tap[k] = 32 - k.
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            a = N'(i);
            e = 1'b1;
            model_shift(N'(i));
        end
        @(negedge clk);
        e = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            addr = AW'(k);
            #1;
            check("fill_z", z, 32 - k);
        end

        begin_dump(1'b0, '0);
        dump_all("full");

        // Enable gating: only 100, 102, 104, 106 enter the chain.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a = N'(100 + c);
            e = (c % 2 == 0);
            if (e) model_shift(a);
        end
        @(negedge clk);
        e = 1'b0;
        addr = 5'd0; #1; check("en_z0", z, 106);
        addr = 5'd1; #1; check("en_z1", z, 104);
        addr = 5'd2; #1; check("en_z2", z, 102);
        addr = 5'd3; #1; check("en_z3", z, 100);
        addr = 5'd4; #1; check("en_z4", z, 32);
        addr = 5'd5; #1; check("en_z5", z, 31);

        // Backpressure with e toggling throughout the dump.
        begin_dump(1'b0, '0);
        pat   = 32'h6C3A_B52D;
        exp_i = 0;
        cyc   = 0;
        while (exp_i < DEPTH && cyc < 200) begin
            @(negedge clk);
            dump_ready = pat[cyc % 32];
            e          = ~e;
            a          = N'($urandom);
            check("bp_valid", dump_valid, 1'b1);
            check("bp_idx", dump_idx, exp_i);
            check("bp_data", dump_data, m[exp_i]);
            @(posedge clk);
            if (dump_ready) exp_i++;
            cyc++;
        end
        check("bp_count", exp_i, DEPTH);
        @(negedge clk);
        e = 1'b0;
        dump_ready = 1'b0;
        check("bp_busy_end", busy, 1'b0);
        addr = 5'd0; #1; check("bp_noshift_z0", z, m[0]);
        addr = 5'd31; #1; check("bp_noshift_z31", z, m[31]);

        // Abort after the 10th transfer; reset beats start and e on the same edge.
        begin_dump(1'b0, '0);
        dump_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ab_idx", dump_idx, i);
        end
        @(negedge clk);
        check("ab_idx10", dump_idx, 10);
        rst = 1'b1; start = 1'b1; e = 1'b1; a = 8'h55;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; e = 1'b0;
        @(negedge clk);
        check("ab_busy", busy, 1'b0);
        check("ab_valid", dump_valid, 1'b0);
        check("ab_idx0", dump_idx, 0);
        addr = 5'd0; #1; check("ab_noshift_z0", z, m[0]);
        begin_dump(1'b0, '0);
        dump_all("rerun");

        // Start together with a shift of 0xAA.
        old30 = m[30];
        begin_dump(1'b1, 8'hAA);
        dump_all("sim");
        check("sim_first", got_first, 8'hAA);
        check("sim_last", got_last, old30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/srl_readback.md
SRL_READBACK -- requirements
Module: srl_readback

Interface
REQ-001 Parameter N, default 8, data width in bits.
REQ-002 Parameter DEPTH, default 32, shift-chain depth in words; power of two, 2..64.
REQ-003 Derived constant AW = log2(DEPTH), address width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port a, input, N bits: word shifted into tap 0.
REQ-007 Port e, input, 1 bit: shift enable.
REQ-008 Port addr, input, AW bits: dynamic tap select for z.
REQ-009 Port z, output, N bits: combinational tap[addr].
REQ-010 Port start, input, 1 bit: request a full-chain readback.
REQ-011 Port busy, output, 1 bit: readback in progress.
REQ-012 Port dump_valid, output, 1 bit: dump word available.
REQ-013 Port dump_ready, input, 1 bit: consumer accepts the dump word.
REQ-014 Port dump_data, output, N bits: tap[dump_idx].
REQ-015 Port dump_idx, output, AW bits: index of the current dump word.
REQ-016 Port dump_last, output, 1 bit: high with dump_valid when dump_idx == DEPTH-1.

Function
REQ-017 Shift: on a clock edge with e=1 and busy=0, tap[k] <= tap[k-1] for k = 1..DEPTH-1, and tap[0] <= a; with e=0, taps hold.
REQ-018 z equals tap[addr] combinationally (zero-latency SRL dynamic read); z is independent of busy.
REQ-019 FSM states: IDLE and SEND.
REQ-020 IDLE to SEND when start=1; dump_idx <= 0, and busy and dump_valid are 1 from the next cycle.
REQ-021 If start and e are both 1 in IDLE, the shift is performed; the dump reflects post-shift contents.
REQ-022 While busy=1, e is ignored and the taps are frozen.
REQ-023 In SEND, dump_valid=1, dump_data = tap[dump_idx] combinationally, and dump_data/dump_idx remain stable while dump_ready=0.
REQ-024 Transfer: dump_valid and dump_ready high on an edge; dump_idx increments by 1.
REQ-025 Transfer with dump_idx == DEPTH-1: go to IDLE, dump_idx <= 0, busy=0, dump_valid=0 on the next cycle; no wrap to a second pass.
REQ-026 start while busy=1 is ignored.
REQ-027 Exactly DEPTH transfers occur per readback, in order tap[0] (newest) to tap[DEPTH-1] (oldest).

Reset
REQ-028 rst=1 on an edge forces IDLE, with busy=0, dump_valid=0, and dump_idx=0; these are the reset values of all registered outputs.
REQ-029 Tap storage has no reset (required for SRL inference); z and dump_data are undefined until DEPTH shifts have occurred.
REQ-030 rst during SEND aborts the readback, leaves tap contents unchanged, and re-enables shifting from the next cycle.
REQ-031 rst has priority over start and e in the same cycle; no shift occurs on a reset edge.

Structure
REQ-032 Package srl_readback_pkg holds the FSM state type (IDLE, SEND) and the AW derivation function.
REQ-033 Sub-module srl_chain holds the storage, the shift logic with a clock-enable, and two dynamic read ports (addr, dump_idx); it contains no reset, so that synthesis maps it to SRL primitives.
REQ-034 srl_readback contains only the FSM, the index counter and output logic, and instantiates srl_chain once.

Verification
REQ-035 Fill test (N=8, DEPTH=32): shift a = 1..32 with e=1, then sweep addr 0..31 -> z = 32, 31, ..., 1.
REQ-036 Enable test: alternate e 1/0 while a increments every cycle -> only words sampled with e=1 appear at the taps, and no shift occurs when e=0.
REQ-037 Full-speed dump: after the fill, pulse start with dump_ready held 1 -> 32 consecutive dump_valid cycles, data 32..1, dump_idx 0..31, dump_last only on idx 31, then busy=0.
REQ-038 Backpressure: drive dump_ready randomly and toggle e=1 during the dump -> data/idx stable while ready=0, the sequence is unchanged, and taps are not shifted.
REQ-039 Abort: assert rst after the 10th transfer -> busy=0 and dump_valid=0 next cycle; a new start dumps the same 32 words from idx 0.
REQ-040 Simultaneous start with e=1, a=0xAA -> first dump word is 0xAA and the last dump word is the previous tap[30].
